// File: rtl/alulogic_arbiter_if.sv
// Request/response bundle between the per-lane issuers and the shared logic-unit arbiter.
// The master side drives requests and response acceptance; the slave side is the arbiter.
interface alulogic_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_op;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic [IDW-1:0]     resp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/alulogic_arbiter.sv
// Round-robin arbiter time-multiplexing one 32-bit AND/OR logic unit between NREQ requesters.
// Accept in IDLE, evaluate in EXEC, hold a registered tagged result in RESP until taken.
module alulogic_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  alulogic_arbiter_if.slave  bus,
  output logic               busy,
  output logic [31:0]        op_count
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e         state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] grant_id_q;
  logic [IDW-1:0] resp_id_q;
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  logic           op_q;
  logic [31:0]    resp_data_q;
  logic           resp_valid_q;
  logic           busy_q;
  logic [31:0]    op_count_q;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] cand;
  logic [31:0]    alu_result;

  // Search starts just after the last served requester and wraps, giving round-robin fairness.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle && win_found && !rst) ? (NREQ'(1) << win_id) : '0;

  // Shared alulogic datapath: fed only from the latched operands, so it settles during EXEC.
  assign alu_result = op_q ? (a_q | b_q) : (a_q & b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IDW'(NREQ - 1);
      grant_id_q   <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found) begin
            a_q        <= bus.req_a[{win_id, 5'd0} +: 32];
            b_q        <= bus.req_b[{win_id, 5'd0} +: 32];
            op_q       <= bus.req_op[win_id];
            grant_id_q <= win_id;
            busy_q     <= 1'b1;
            state_q    <= StExec;
          end
        end
        StExec: begin
          resp_data_q  <= alu_result;
          resp_id_q    <= grant_id_q;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            last_grant_q <= grant_id_q;
            op_count_q   <= op_count_q + 32'd1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = busy_q;
  assign op_count       = op_count_q;
endmodule
